// File: rtl/led_matrix_pkg.sv
// Shared LED matrix types and defaults for the scan driver, frame source and RAM.
package led_matrix_pkg;

    localparam int DEF_ROW_W    = 32;
    localparam int DEF_NUM_ROWS = 16;

    typedef enum logic [1:0] {
        SHIFT = 2'd0,
        BLANK = 2'd1,
        LATCH = 2'd2
    } scan_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/row_shift_reg.sv
// Serial-to-parallel row assembler; LSB_FIRST picks which end the first bit lands in.
module row_shift_reg #(
    parameter int ROW_W     = 32,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             bit_i,
    output logic [ROW_W-1:0] data_o
);

    logic [ROW_W-1:0] data_q;
    logic [ROW_W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (shift_en) begin
            if (LSB_FIRST) begin
                data_d = {bit_i, data_q[ROW_W-1:1]};
            end else begin
                data_d = {data_q[ROW_W-2:0], bit_i};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/led_scan_ctrl.sv
// Row scan driver: shift, blank, latch, advance one-hot row select.
// Optional PWM dimming on oe_o when LED_SCAN_PWM_EN is defined.
module led_scan_ctrl
    import led_matrix_pkg::*;
#(
    parameter int ROW_W     = DEF_ROW_W,
    parameter int NUM_ROWS  = DEF_NUM_ROWS,
    parameter bit LSB_FIRST = 1'b1,
    parameter int BLANK_CYC = 2,
`ifdef LED_SCAN_PWM_EN
    parameter int BRT_W     = 4,
`endif
    localparam int IDX_W    = idx_w(NUM_ROWS)
) (
    input  logic                clk,
    input  logic                rst,
`ifdef LED_SCAN_PWM_EN
    input  logic [BRT_W-1:0]    brightness_i,
`endif
    input  logic                serial_valid_i,
    input  logic                serial_i,
    output logic                serial_ready_o,
    output logic [ROW_W-1:0]    row_o,
    output logic [NUM_ROWS-1:0] row_sel_o,
    output logic [IDX_W-1:0]    row_idx_o,
    output logic                oe_o,
    output logic                frame_done_o
);

    localparam int CNT_W = idx_w(ROW_W);
    localparam int BLK_W = idx_w(BLANK_CYC);

    scan_state_e         state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [BLK_W-1:0]    blk_cnt_q, blk_cnt_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [NUM_ROWS-1:0] sel_q, sel_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    nxt_q, nxt_d;
    logic                oe_q, oe_d;
    logic                fd_q, fd_d;
    logic                shift_en;
    logic [ROW_W-1:0]    sh_data;

    row_shift_reg #(
        .ROW_W    (ROW_W),
        .LSB_FIRST(LSB_FIRST)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .shift_en(shift_en),
        .bit_i   (serial_i),
        .data_o  (sh_data)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        blk_cnt_d = blk_cnt_q;
        row_d     = row_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        nxt_d     = nxt_q;
        oe_d      = oe_q;
        fd_d      = fd_q;
        shift_en  = 1'b0;
        unique case (state_q)
            SHIFT: begin
                if (serial_valid_i) begin
                    shift_en = 1'b1;
                    if (bit_cnt_q == CNT_W'(ROW_W - 1)) begin
                        bit_cnt_d = '0;
                        blk_cnt_d = '0;
                        state_d   = BLANK;
                        oe_d      = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            BLANK: begin
                if (blk_cnt_q == BLK_W'(BLANK_CYC - 1)) begin
                    state_d = LATCH;
                    row_d   = sh_data;
                    idx_d   = nxt_q;
                    sel_d   = NUM_ROWS'(1) << nxt_q;
                    fd_d    = (nxt_q == IDX_W'(NUM_ROWS - 1));
                    nxt_d   = fd_d ? '0 : nxt_q + IDX_W'(1);
                end else begin
                    blk_cnt_d = blk_cnt_q + BLK_W'(1);
                end
            end
            LATCH: begin
                state_d = SHIFT;
                oe_d    = 1'b1;
                fd_d    = 1'b0;
            end
            default: state_d = SHIFT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SHIFT;
            bit_cnt_q <= '0;
            blk_cnt_q <= '0;
            row_q     <= '0;
            sel_q     <= '0;
            idx_q     <= '0;
            nxt_q     <= '0;
            oe_q      <= 1'b0;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            blk_cnt_q <= blk_cnt_d;
            row_q     <= row_d;
            sel_q     <= sel_d;
            idx_q     <= idx_d;
            nxt_q     <= nxt_d;
            oe_q      <= oe_d;
            fd_q      <= fd_d;
        end
    end

`ifdef LED_SCAN_PWM_EN
    logic [BRT_W-1:0] pwm_cnt_q, pwm_cnt_d;

    always_comb pwm_cnt_d = pwm_cnt_q + BRT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    assign oe_o = oe_q & (pwm_cnt_q < brightness_i);
`else
    assign oe_o = oe_q;
`endif

    assign serial_ready_o = (state_q == SHIFT);
    assign row_o          = row_q;
    assign row_sel_o      = sel_q;
    assign row_idx_o      = idx_q;
    assign frame_done_o   = fd_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Scoreboard bench for led_scan_ctrl: LSB-first and MSB-first instances fed the same stream.
module tb_led_scan_ctrl;

    localparam int RW = 8;
    localparam int NR = 4;
    localparam int BC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          v;
    logic          s;
    logic [RW-1:0] row_l, row_m;
    logic [NR-1:0] sel_l, sel_m;
    logic [1:0]    idx_l, idx_m;
    logic          oe_l, oe_m, fd_l, fd_m, rdy_l, rdy_m;
`ifdef LED_SCAN_PWM_EN
    logic [3:0]    brt;
`endif

    always #5 clk = ~clk;

    led_scan_ctrl #(
        .ROW_W(RW), .NUM_ROWS(NR), .LSB_FIRST(1'b1), .BLANK_CYC(BC)
    ) u_lsb (
        .clk           (clk),
        .rst           (rst),
`ifdef LED_SCAN_PWM_EN
        .brightness_i  (brt),
`endif
        .serial_valid_i(v),
        .serial_i      (s),
        .serial_ready_o(rdy_l),
        .row_o         (row_l),
        .row_sel_o     (sel_l),
        .row_idx_o     (idx_l),
        .oe_o          (oe_l),
        .frame_done_o  (fd_l)
    );

    led_scan_ctrl #(
        .ROW_W(RW), .NUM_ROWS(NR), .LSB_FIRST(1'b0), .BLANK_CYC(BC)
    ) u_msb (
        .clk           (clk),
        .rst           (rst),
`ifdef LED_SCAN_PWM_EN
        .brightness_i  (brt),
`endif
        .serial_valid_i(v),
        .serial_i      (s),
        .serial_ready_o(rdy_m),
        .row_o         (row_m),
        .row_sel_o     (sel_m),
        .row_idx_o     (idx_m),
        .oe_o          (oe_m),
        .frame_done_o  (fd_m)
    );

    typedef struct packed {
        logic [RW-1:0] lsb;
        logic [RW-1:0] msb;
        logic [1:0]    idx;
        logic          fd;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk   = 0;
    int   n_pass  = 0;
    int   exp_idx = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    // Drive n bits, bits[0] first; gap inserts an idle cycle before each bit.
    task automatic send_bits(input logic [RW-1:0] bits, input int n,
                             input bit gap);
        int to;
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                v = 1'b0;
                s = 1'($urandom);
                @(posedge clk); #1;
            end
            v  = 1'b1;
            s  = bits[i];
            to = 0;
            while (!rdy_l && to < 20) begin
                @(posedge clk); #1;
                to++;
            end
            if (to >= 20) check("ready_timeout", 32'(rdy_l), 32'd1);
            @(posedge clk); #1;
        end
    endtask

    task automatic push_exp(input logic [RW-1:0] bits);
        exp_t e;
        e.lsb = bits;
        for (int j = 0; j < RW; j++) e.msb[RW-1-j] = bits[j];
        e.idx   = 2'(exp_idx);
        e.fd    = (exp_idx == NR - 1);
        exp_idx = (exp_idx + 1) % NR;
        sb_q.push_back(e);
    endtask

    // Valid stays high with junk data through blank/latch; none may be taken.
    task automatic check_latch();
        exp_t e;
        v = 1'b1;
        s = 1'($urandom);
        check("blank_rdy", 32'({rdy_l, rdy_m}), 32'd0);
        check("blank_oe", 32'({oe_l, oe_m}), 32'd0);
        for (int k = 1; k <= BC; k++) begin
            @(posedge clk); #1;
            s = 1'($urandom);
            if (k < BC) check("blank_mid_rdy", 32'(rdy_l), 32'd0);
        end
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("row_lsb", 32'(row_l), 32'(e.lsb));
            check("row_msb", 32'(row_m), 32'(e.msb));
            check("row_idx", 32'(idx_l), 32'(e.idx));
            check("row_sel", 32'(sel_l), 32'(4'b0001 << e.idx));
            check("frame_done", 32'({fd_l, fd_m}), e.fd ? 32'd3 : 32'd0);
            check("latch_oe", 32'(oe_l), 32'd0);
            check("latch_rdy", 32'(rdy_l), 32'd0);
        end
        @(posedge clk); #1;
        v = 1'b0;
`ifndef LED_SCAN_PWM_EN
        check("oe_on", 32'({oe_l, oe_m}), 32'd3);
`endif
        check("shift_rdy", 32'({rdy_l, rdy_m}), 32'd3);
        check("fd_pulse_end", 32'(fd_l), 32'd0);
    endtask

    task automatic send_row(input logic [RW-1:0] bits, input bit gap);
        send_bits(bits, RW, gap);
        push_exp(bits);
        check_latch();
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        v   = 1'b0;
        s   = 1'b0;
`ifdef LED_SCAN_PWM_EN
        brt = 4'hF;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_row", 32'(row_l), 32'd0);
        check("rst_sel", 32'(sel_l), 32'd0);
        check("rst_oe", 32'(oe_l), 32'd0);
        check("rst_rdy", 32'(rdy_l), 32'd1);
        rst = 1'b0;

        send_row(8'h0D, 1'b0);
        send_row(8'h5A, 1'b1);
        send_row(8'hC3, 1'b0);
        send_row(8'h81, 1'b0);
        send_row(8'hE7, 1'b1);

        send_bits(8'hFF, 5, 1'b0);
        v   = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_row", 32'(row_l), 32'd0);
        check("mrst_sel", 32'(sel_l), 32'd0);
        check("mrst_idx", 32'(idx_l), 32'd0);
        check("mrst_oe_fd", 32'({oe_l, fd_l}), 32'd0);
        check("mrst_rdy", 32'(rdy_l), 32'd1);
        exp_idx = 0;
        send_row(8'h96, 1'b0);

`ifdef LED_SCAN_PWM_EN
        brt = 4'd4;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            cnt += int'(oe_l);
        end
        check("pwm_duty4", 32'(cnt), 32'd4);
        brt = 4'd0;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            cnt += int'(oe_l);
        end
        check("pwm_dark", 32'(cnt), 32'd0);
`else
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            cnt += int'(oe_l);
        end
        check("idle_oe", 32'(cnt), 32'd16);
`endif

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/led_scan_ctrl.md
Name: led_scan_ctrl

Overview:
Parametrised successor to the serial-row scan driver. It shrinks serial pixel bits into a ROW_W-bit row, latches each full row to the column drivers, and advances a one-hot row select that wraps every NUM_ROWS rows. Adds valid/ready input flow control, a blanking window around each row switch, a frame-done pulse and a selectable bit order. It sits between the frame source (serial bitstream) and the matrix pin drivers; a file-dump monitor can tap row_o on frame_done_o/row_idx_o.

Parameters:
ROW_W, 32, pixels per row (>=2)
NUM_ROWS, 16, rows per frame (>=2)
LSB_FIRST, 1, 1: first accepted bit lands in row_o[0]; 0: first bit lands in row_o[ROW_W-1]
BLANK_CYC, 2, cycles oe_o held low before a row switch (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
serial_valid_i  in  1  serial_i carries a pixel bit
serial_i  in  1  pixel bit
serial_ready_o  out  1  block accepts a bit this cycle (combinational, = state==SHIFT)
row_o  out  ROW_W  latched row pixel data
row_sel_o  out  NUM_ROWS  one-hot row select
row_idx_o  out  clog2(NUM_ROWS)  index of the active row
oe_o  out  1  LED output enable, active-high
frame_done_o  out  1  one-cycle pulse when the last row of a frame is latched

Behaviour:
- Reset (sync, rst=1 at posedge): state=SHIFT, bit_cnt=0, shift reg=0, row_o=0, row_sel_o=0, row_idx_o=0, oe_o=0, frame_done_o=0, next_idx=0. Mid-operation reset discards the partial row.
- A bit is accepted on an edge with serial_valid_i & serial_ready_o. When ready=0, valid is ignored and no bit is lost from the count.
- LSB_FIRST=1: shift right, new bit enters at MSB. After ROW_W bits, the first bit is in bit 0. LSB_FIRST=0: shift left, new bit enters at bit 0.
- FSM SHIFT -> BLANK -> LATCH -> SHIFT:
  - SHIFT: on the edge (E0) that accepts bit ROW_W-1 (bit_cnt==ROW_W-1), bit_cnt<=0, state<=BLANK, oe_o<=0.
  - BLANK: lasts exactly BLANK_CYC cycles. On its final edge, state<=LATCH, row_o<=shift reg, row_idx_o<=next_idx, row_sel_o<=one-hot(next_idx), next_idx<=(next_idx==NUM_ROWS-1)?0:next_idx+1. frame_done_o<=1 iff next_idx==NUM_ROWS-1.
  - LATCH: one cycle, oe_o still 0. Next edge: state<=SHIFT, oe_o<=1, frame_done_o<=0.
- oe_o and serial_ready_o are low for BLANK_CYC+1 cycles per row. oe_o stays 0 from reset until the first LATCH completes.
- Latency from the last accepted bit (E0) to row_o update = BLANK_CYC edges. oe_o rises at E0+BLANK_CYC+1.
- Wrap: after row NUM_ROWS-1, the next row is 0. row_sel_o is never all-zero after the first latch. Exactly one bit is set.
- Throughput: one row per ROW_W+BLANK_CYC+1 cycles with continuous valid.

Optional Feature:
LED_SCAN_PWM_EN.
- Defined: adds parameter BRT_W (default 4), input brightness_i[BRT_W-1:0], and a free-running pwm_cnt (reset 0, wraps). Effective oe_o = base_oe & (pwm_cnt < brightness_i). brightness 0 = dark; all-ones = (2^BRT_W-1)/2^BRT_W duty. Blanking still forces 0.
- Undefined: no port, no counter, oe_o = base_oe.

Decomposition:
- Package led_matrix_pkg: scan_state_e enum (SHIFT, BLANK, LATCH), function for index width clog2, default ROW_W/NUM_ROWS constants shared with the frame source and RAM.
- One sub-module, row_shift_reg (ROW_W, LSB_FIRST; shift_en, bit_i, data_o). FSM, counters and select stay in the top module.

Test Plan:
1. ROW_W=8, NUM_ROWS=4, LSB_FIRST=1, BLANK_CYC=2; continuous valid, bits 1,0,1,1,0,0,0,0 -> row_o=8'h0D two edges after the 8th bit, row_sel_o=4'b0001, row_idx_o=0, oe_o=1 three edges after.
2. Same stream with LSB_FIRST=0 -> row_o=8'hB0.
3. Send 4 rows -> frame_done_o high for exactly one cycle with row 3 (row_sel_o=4'b1000). 5th row -> row_sel_o=4'b0001, idx 0.
4. Toggle valid 1,0,1,0 during SHIFT, and assert valid during BLANK/LATCH -> only SHIFT-cycle valid bits counted; row_o matches the accepted bits exactly.
5. rst asserted after 5 of 8 bits -> all outputs return to reset values next cycle. A fresh 8-bit row latches correctly into row 0.
6. LED_SCAN_PWM_EN, BRT_W=4, brightness_i=4 -> in steady SHIFT, oe_o high 4 of every 16 cycles. brightness_i=0 -> oe_o constantly 0.
